// File: rtl/id_ctrl_stage.sv
// id_ctrl_stage: RV32I decode/control stage producing the ID/EX control register.
// Adds a valid/ready handshake, redirect flush, load-use interlock and illegal flagging.
module id_ctrl_stage #(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_valid,
  input  logic [31:0]           if_instr,
  input  logic [XLEN-1:0]       if_pc,
  output logic                  id_ready,
  input  logic                  ex_ready,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
  output logic                  ex_alu_src,
  output logic                  ex_mem_wen,
  output logic                  ex_mem_ren,
  output logic                  ex_reg_wb,
  output logic                  ex_branch,
  output logic                  ex_jal,
  output logic                  ex_jalr,
  output logic                  ex_auipc,
  output logic [2:0]            ex_funct3,
  output logic [4:0]            ex_rs1,
  output logic [4:0]            ex_rs2,
  output logic [4:0]            ex_rd,
  output logic [XLEN-1:0]       ex_imm,
  output logic [XLEN-1:0]       ex_pc,
  output logic                  ex_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = ALU_CTRL_W'(5'h00);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = ALU_CTRL_W'(5'h01);
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = ALU_CTRL_W'(5'h02);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR    = ALU_CTRL_W'(5'h03);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND   = ALU_CTRL_W'(5'h04);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL   = ALU_CTRL_W'(5'h05);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL   = ALU_CTRL_W'(5'h06);
  localparam logic [ALU_CTRL_W-1:0] ALU_BEQ   = ALU_CTRL_W'(5'h07);
  localparam logic [ALU_CTRL_W-1:0] ALU_BNE   = ALU_CTRL_W'(5'h08);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = ALU_CTRL_W'(5'h09);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA   = ALU_CTRL_W'(5'h0A);
  localparam logic [ALU_CTRL_W-1:0] ALU_AUIPC = ALU_CTRL_W'(5'h0B);
  localparam logic [ALU_CTRL_W-1:0] ALU_BLT   = ALU_CTRL_W'(5'h0C);
  localparam logic [ALU_CTRL_W-1:0] ALU_BGE   = ALU_CTRL_W'(5'h0D);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU  = ALU_CTRL_W'(5'h0E);
  localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = ALU_CTRL_W'(5'h0F);
  localparam logic [ALU_CTRL_W-1:0] ALU_BLTU  = ALU_CTRL_W'(5'h10);
  localparam logic [ALU_CTRL_W-1:0] ALU_BGEU  = ALU_CTRL_W'(5'h11);

  typedef struct packed {
    logic                  valid;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  alu_src;
    logic                  mem_wen;
    logic                  mem_ren;
    logic                  reg_wb;
    logic                  branch;
    logic                  jal;
    logic                  jalr;
    logic                  auipc;
    logic [2:0]            funct3;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       pc;
    logic                  illegal;
  } ex_t;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_BUBBLE = 1'b1} state_t;

  // Sign-extend a 32-bit immediate to the datapath width.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    sext32 = {{(XLEN-31){v[31]}}, v[30:0]};
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd;
  logic       f7_zero, f7_alt;
  logic       uses_rs2;
  logic       ill;
  logic [31:0] imm32;
  logic       hazard;
  ex_t        dec;
  ex_t        ex_d, ex_q;
  state_t     state_d, state_q;

  assign opcode  = if_instr[6:0];
  assign rd      = if_instr[11:7];
  assign funct3  = if_instr[14:12];
  assign rs1     = if_instr[19:15];
  assign rs2     = if_instr[24:20];
  assign funct7  = if_instr[31:25];
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  // Decode the IF/ID instruction into a candidate ID/EX record.
  always_comb begin
    dec          = '0;
    ill          = 1'b0;
    imm32        = 32'd0;
    uses_rs2     = 1'b0;
    dec.valid    = 1'b1;
    dec.alu_ctrl = ALU_ADD;
    dec.funct3   = funct3;
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.rd       = rd;
    dec.pc       = if_pc;
    case (opcode)
      OPC_LUI: begin
        dec.alu_ctrl = ALU_PASSB; dec.alu_src = 1'b1; dec.reg_wb = 1'b1;
        imm32 = {if_instr[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        dec.alu_ctrl = ALU_AUIPC; dec.alu_src = 1'b1; dec.reg_wb = 1'b1; dec.auipc = 1'b1;
        imm32 = {if_instr[31:12], 12'd0};
      end
      OPC_JAL: begin
        dec.alu_src = 1'b1; dec.reg_wb = 1'b1; dec.jal = 1'b1;
        imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        dec.alu_src = 1'b1; dec.reg_wb = 1'b1; dec.jalr = 1'b1;
        imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
        ill = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1; uses_rs2 = 1'b1;
        imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
        case (funct3)
          3'b000:  dec.alu_ctrl = ALU_BEQ;
          3'b001:  dec.alu_ctrl = ALU_BNE;
          3'b100:  dec.alu_ctrl = ALU_BLT;
          3'b101:  dec.alu_ctrl = ALU_BGE;
          3'b110:  dec.alu_ctrl = ALU_BLTU;
          3'b111:  dec.alu_ctrl = ALU_BGEU;
          default: ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.alu_src = 1'b1; dec.mem_ren = 1'b1; dec.reg_wb = 1'b1;
        imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
        ill = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec.alu_src = 1'b1; dec.mem_wen = 1'b1; uses_rs2 = 1'b1;
        imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
        ill = (funct3[2] == 1'b1) | (funct3 == 3'b011);
      end
      OPC_OPIMM: begin
        dec.alu_src = 1'b1; dec.reg_wb = 1'b1;
        imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
        case (funct3)
          3'b000:  dec.alu_ctrl = ALU_ADD;
          3'b010:  dec.alu_ctrl = ALU_SLT;
          3'b011:  dec.alu_ctrl = ALU_SLTU;
          3'b100:  dec.alu_ctrl = ALU_XOR;
          3'b110:  dec.alu_ctrl = ALU_OR;
          3'b111:  dec.alu_ctrl = ALU_AND;
          3'b001:  begin dec.alu_ctrl = ALU_SLL; ill = ~f7_zero; end
          3'b101:  begin dec.alu_ctrl = f7_alt ? ALU_SRA : ALU_SRL; ill = ~(f7_zero | f7_alt); end
          default: ill = 1'b1;
        endcase
      end
      OPC_OP: begin
        dec.reg_wb = 1'b1; uses_rs2 = 1'b1;
        case (funct3)
          3'b000:  begin dec.alu_ctrl = f7_alt ? ALU_SUB : ALU_ADD; ill = ~(f7_zero | f7_alt); end
          3'b101:  begin dec.alu_ctrl = f7_alt ? ALU_SRA : ALU_SRL; ill = ~(f7_zero | f7_alt); end
          3'b001:  begin dec.alu_ctrl = ALU_SLL;  ill = ~f7_zero; end
          3'b010:  begin dec.alu_ctrl = ALU_SLT;  ill = ~f7_zero; end
          3'b011:  begin dec.alu_ctrl = ALU_SLTU; ill = ~f7_zero; end
          3'b100:  begin dec.alu_ctrl = ALU_XOR;  ill = ~f7_zero; end
          3'b110:  begin dec.alu_ctrl = ALU_OR;   ill = ~f7_zero; end
          3'b111:  begin dec.alu_ctrl = ALU_AND;  ill = ~f7_zero; end
          default: ill = 1'b1;
        endcase
      end
      OPC_FENCE: ill = (funct3 != 3'b000);
      default:   ill = 1'b1;
    endcase
    dec.imm     = sext32(imm32);
    dec.illegal = ill;
    // Illegal instructions travel as valid but may not touch state or redirect.
    dec.mem_wen = dec.mem_wen & ~ill;
    dec.mem_ren = dec.mem_ren & ~ill;
    dec.branch  = dec.branch  & ~ill;
    dec.jal     = dec.jal     & ~ill;
    dec.jalr    = dec.jalr    & ~ill;
    dec.reg_wb  = dec.reg_wb  & ~ill & (rd != 5'd0);
  end

  assign hazard = ex_q.valid & ex_q.mem_ren & (ex_q.rd != 5'd0) &
                  ((ex_q.rd == rs1) | ((ex_q.rd == rs2) & uses_rs2));

  // Select the next ID/EX contents by update priority.
  always_comb begin
    ex_d = '0;
    if (flush) begin
      ex_d = '0;
    end else if (!ex_ready) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = '0;
    end else if (if_valid) begin
      ex_d = dec;
    end else begin
      ex_d = '0;
    end
  end

  // FSM next state: a hazard accepted by EX inserts exactly one bubble.
  always_comb begin
    state_d = ST_RUN;
    if (flush) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:    state_d = (hazard & ex_ready) ? ST_BUBBLE : ST_RUN;
        ST_BUBBLE: state_d = ST_RUN;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  // FSM output: accept a new instruction only when it can move into ID/EX.
  always_comb begin
    id_ready = 1'b0;
    case (state_q)
      ST_RUN:    id_ready = ~flush & ex_ready & ~hazard;
      ST_BUBBLE: id_ready = ~flush & ex_ready & ~hazard;
      default:   id_ready = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign ex_valid    = ex_q.valid;
  assign ex_alu_ctrl = ex_q.alu_ctrl;
  assign ex_alu_src  = ex_q.alu_src;
  assign ex_mem_wen  = ex_q.mem_wen;
  assign ex_mem_ren  = ex_q.mem_ren;
  assign ex_reg_wb   = ex_q.reg_wb;
  assign ex_branch   = ex_q.branch;
  assign ex_jal      = ex_q.jal;
  assign ex_jalr     = ex_q.jalr;
  assign ex_auipc    = ex_q.auipc;
  assign ex_funct3   = ex_q.funct3;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_imm      = ex_q.imm;
  assign ex_pc       = ex_q.pc;
  assign ex_illegal  = ex_q.illegal;

endmodule
